// File: rtl/circle_test_pipe_if.sv
// rtl/circle_test_pipe_if.sv - converter and consumer signal bundle for circle_test_pipe
// master: the classifier side; slave: converters plus consumer.
interface circle_test_pipe_if #(
   parameter int N     = 8,
   parameter int CNT_W = 16
);
   logic                soc_x;
   logic                eoc_x;
   logic signed [N-1:0] x;
   logic                soc_y;
   logic                eoc_y;
   logic signed [N-1:0] y;
   logic                dav_;
   logic                rfd;
   logic                z;
   logic [CNT_W-1:0]    count;
   logic                cnt_clr;

   modport master (
      output soc_x, soc_y, dav_, z, count,
      input  eoc_x, x, eoc_y, y, rfd, cnt_clr
   );

   modport slave (
      input  soc_x, soc_y, dav_, z, count,
      output eoc_x, x, eoc_y, y, rfd, cnt_clr
   );
endinterface

// File: rtl/circle_test_pipe.sv
// rtl/circle_test_pipe.sv - point-in-disc classifier with converter start/capture and dav_/rfd delivery
// Samples X/Y, squares magnitudes, compares the sum to R2, hands z downstream and counts inside hits.
module circle_test_pipe #(
   parameter int             N         = 8,
   parameter logic [2*N-1:0] R2        = (2*N)'(4096),
   parameter bit             INCLUSIVE = 1'b1,
   parameter int             CNT_W     = 16
) (
   input logic                clock,
   input logic                reset,
   circle_test_pipe_if.master bus
);
   typedef enum logic [2:0] {
      S_SOC = 3'd0,
      S_EOC = 3'd1,
      S_SQ  = 3'd2,
      S_CMP = 3'd3,
      S_DAV = 3'd4,
      S_ACK = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             soc_q, soc_d;
   logic             fx_q, fx_d;
   logic             fy_q, fy_d;
   logic             dav_n_q, dav_n_d;
   logic             z_q, z_d;
   logic [N-1:0]     x_q, x_d;
   logic [N-1:0]     y_q, y_d;
   logic [2*N-1:0]   sqx_q, sqx_d;
   logic [2*N-1:0]   sqy_q, sqy_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [N-1:0]     ax, ay;
   logic [2*N-1:0]   sum;
   logic             in_disc;

   // Magnitude as unsigned N bits so the most negative sample maps to 2^(N-1) without wrapping.
   always_comb begin
      ax      = x_q[N-1] ? (~x_q + 1'b1) : x_q;
      ay      = y_q[N-1] ? (~y_q + 1'b1) : y_q;
      sum     = sqx_q + sqy_q;
      in_disc = INCLUSIVE ? (sum <= R2) : (sum < R2);
   end

   always_comb begin
      state_d = state_q;
      soc_d   = soc_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      dav_n_d = dav_n_q;
      z_d     = z_q;
      x_d     = x_q;
      y_d     = y_q;
      sqx_d   = sqx_q;
      sqy_d   = sqy_q;
      count_d = count_q;
      case (state_q)
         S_SOC: begin
            fx_d  = 1'b0;
            fy_d  = 1'b0;
            soc_d = 1'b1;
            if (soc_q && !bus.eoc_x && !bus.eoc_y) begin
               soc_d   = 1'b0;
               state_d = S_EOC;
            end
         end
         S_EOC: begin
            if (bus.eoc_x && !fx_q) begin
               x_d  = bus.x;
               fx_d = 1'b1;
            end
            if (bus.eoc_y && !fy_q) begin
               y_d  = bus.y;
               fy_d = 1'b1;
            end
            if ((fx_q || bus.eoc_x) && (fy_q || bus.eoc_y))
               state_d = S_SQ;
         end
         S_SQ: begin
            sqx_d   = {{N{1'b0}}, ax} * {{N{1'b0}}, ax};
            sqy_d   = {{N{1'b0}}, ay} * {{N{1'b0}}, ay};
            state_d = S_CMP;
         end
         S_CMP: begin
            z_d     = in_disc;
            dav_n_d = 1'b0;
            if (in_disc && (count_q != {CNT_W{1'b1}}))
               count_d = count_q + 1'b1;
            state_d = S_DAV;
         end
         S_DAV: begin
            if (!bus.rfd) begin
               dav_n_d = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (bus.rfd) begin
               soc_d   = 1'b1;
               state_d = S_SOC;
            end
         end
         default: begin
            soc_d   = 1'b0;
            dav_n_d = 1'b1;
            state_d = S_SOC;
         end
      endcase
      // Clear beats a coincident increment and applies in every state.
      if (bus.cnt_clr)
         count_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_SOC;
         soc_q   <= 1'b0;
         fx_q    <= 1'b0;
         fy_q    <= 1'b0;
         dav_n_q <= 1'b1;
         z_q     <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         sqx_q   <= '0;
         sqy_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         soc_q   <= soc_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         dav_n_q <= dav_n_d;
         z_q     <= z_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sqx_q   <= sqx_d;
         sqy_q   <= sqy_d;
         count_q <= count_d;
      end
   end

   assign bus.soc_x = soc_q;
   assign bus.soc_y = soc_q;
   assign bus.dav_  = dav_n_q;
   assign bus.z     = z_q;
   assign bus.count = count_q;
endmodule

// File: tb/tb_circle_test_pipe.sv
// tb/tb_circle_test_pipe.sv - randomized self-checking bench for circle_test_pipe
// Two instances share stimulus: A (inclusive, 16-bit count) and B (exclusive, 2-bit count).
module tb_circle_test_pipe;
   logic       clock = 1'b0;
   logic       reset;
   logic       eoc_x, eoc_y, rfd, cnt_clr;
   logic [7:0] xd, yd;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_a    = 0;
   int cnt_b    = 0;

   always #5 clock = ~clock;

   circle_test_pipe_if #(.N(8), .CNT_W(16)) bus_a ();
   circle_test_pipe_if #(.N(8), .CNT_W(2))  bus_b ();

   assign bus_a.eoc_x = eoc_x;   assign bus_b.eoc_x = eoc_x;
   assign bus_a.eoc_y = eoc_y;   assign bus_b.eoc_y = eoc_y;
   assign bus_a.x     = xd;      assign bus_b.x     = xd;
   assign bus_a.y     = yd;      assign bus_b.y     = yd;
   assign bus_a.rfd   = rfd;     assign bus_b.rfd   = rfd;
   assign bus_a.cnt_clr = cnt_clr;
   assign bus_b.cnt_clr = cnt_clr;

   circle_test_pipe #(.N(8), .R2(16'd4096), .INCLUSIVE(1'b1), .CNT_W(16)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   circle_test_pipe #(.N(8), .R2(16'd4096), .INCLUSIVE(1'b0), .CNT_W(2)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_soc(input logic v);
      int n = 0;
      while (bus_a.soc_x !== v && n < 40) begin
         step();
         n++;
      end
      chk("soc_wait", {31'd0, bus_a.soc_x}, {31'd0, v});
   endtask

   // clr_mode: 0 none, 1 clear on the compare edge, 2 clear while holding dav_
   task automatic do_point(input int xv, input int yv, input int dx, input int dy,
                           input int x_alt, input int clr_mode);
      int  sum, kmax;
      bit  za, zb;
      sum  = xv * xv + yv * yv;
      za   = (sum <= 4096);
      zb   = (sum < 4096);
      kmax = (dx > dy) ? dx : dy;
      wait_soc(1'b1);
      chk("soc_y_mirror", {31'd0, bus_a.soc_y}, 32'd1);
      step();
      wait_soc(1'b0);
      for (int k = 0; k <= kmax; k++) begin
         if (k == dx) begin eoc_x = 1'b1; xd = xv[7:0]; end
         else if (k > dx && x_alt >= 0) xd = x_alt[7:0];
         if (k == dy) begin eoc_y = 1'b1; yd = yv[7:0]; end
         else if (k > dy) yd = 8'($urandom_range(0, 255));
         step();
      end
      step();
      chk("dav_early", {31'd0, bus_a.dav_}, 32'd1);
      if (clr_mode == 1) cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("dav_latency", {31'd0, bus_a.dav_}, 32'd0);
      if (clr_mode == 1) begin
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         cnt_a = (cnt_a + int'(za) > 65535) ? 65535 : cnt_a + int'(za);
         cnt_b = (cnt_b + int'(zb) > 3) ? 3 : cnt_b + int'(zb);
      end
      chk("z_a", {31'd0, bus_a.z}, {31'd0, za});
      chk("z_b", {31'd0, bus_b.z}, {31'd0, zb});
      chk("count_a", {16'd0, bus_a.count}, cnt_a);
      chk("count_b", {30'd0, bus_b.count}, cnt_b);
      for (int h = 0; h < 10; h++) begin
         if (clr_mode == 2 && h == 4) cnt_clr = 1'b1;
         step();
         cnt_clr = 1'b0;
         chk("hold_dav", {31'd0, bus_a.dav_}, 32'd0);
         chk("hold_z", {30'd0, bus_b.z, bus_a.z}, {30'd0, zb, za});
         chk("hold_soc", {31'd0, bus_a.soc_x}, 32'd0);
      end
      if (clr_mode == 2) begin
         cnt_a = 0;
         cnt_b = 0;
         chk("clr_in_dav", {16'd0, bus_a.count}, 32'd0);
      end
      rfd   = 1'b0;
      eoc_x = 1'b0;
      eoc_y = 1'b0;
      step();
      chk("dav_release", {31'd0, bus_a.dav_}, 32'd1);
      for (int h = 0; h < 2; h++) begin
         step();
         chk("ack_soc_low", {31'd0, bus_a.soc_x}, 32'd0);
      end
      rfd = 1'b1;
      step();
      chk("soc_after_rfd", {31'd0, bus_a.soc_x}, 32'd1);
   endtask

   initial begin
      int rx, ry;
      reset = 1'b1; eoc_x = 1'b0; eoc_y = 1'b0; rfd = 1'b1; cnt_clr = 1'b0;
      xd = '0; yd = '0;
      step();
      step();
      chk("rst_soc", {31'd0, bus_a.soc_x}, 32'd0);
      chk("rst_dav", {31'd0, bus_a.dav_}, 32'd1);
      chk("rst_z", {31'd0, bus_a.z}, 32'd0);
      chk("rst_count", {16'd0, bus_a.count}, 32'd0);
      reset = 1'b0;
      step();
      chk("soc_first", {31'd0, bus_a.soc_x}, 32'd1);

      do_point(64, 0, 0, 0, -1, 0);
      do_point(-128, 0, 1, 0, -1, 0);
      do_point(-45, 45, 0, 2, -1, 0);
      do_point(40, 0, 0, 5, 100, 0);
      do_point(30, -30, 2, 2, -1, 0);
      do_point(-10, 5, 3, 1, 7, 0);
      do_point(-128, -128, 0, 0, -1, 0);
      do_point(20, 20, 1, 0, -1, 1);
      do_point(-63, 0, 0, 1, -1, 0);
      do_point(12, 12, 0, 0, -1, 2);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            rx = int'($urandom_range(0, 90)) - 45;
            ry = int'($urandom_range(0, 90)) - 45;
         end else begin
            rx = int'($urandom_range(0, 255)) - 128;
            ry = int'($urandom_range(0, 255)) - 128;
         end
         do_point(rx, ry, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 1)) * int'($urandom_range(0, 255)) - 1,
                  (i % 8 == 7) ? 1 : 0);
      end

      // Abort in S_EOC with the X flag already set; the stale X must not be reused.
      wait_soc(1'b1);
      step();
      wait_soc(1'b0);
      eoc_x = 1'b1;
      xd    = 8'd0;
      step();
      reset = 1'b1;
      step();
      chk("abort_soc", {31'd0, bus_a.soc_x}, 32'd0);
      chk("abort_dav", {31'd0, bus_a.dav_}, 32'd1);
      chk("abort_count", {16'd0, bus_a.count}, 32'd0);
      chk("abort_count_b", {30'd0, bus_b.count}, 32'd0);
      cnt_a = 0;
      cnt_b = 0;
      reset = 1'b0;
      eoc_x = 1'b0;
      step();
      chk("abort_soc_restart", {31'd0, bus_a.soc_x}, 32'd1);
      do_point(100, 100, 3, 0, -1, 0);
      do_point(0, 0, 0, 0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
